// File: rtl/dijkstra_ctrl.sv
// Dijkstra shortest-path search controller: holds cost/parent/visited tables, relaxes
// six children per node fetched from external node memory. Optional macro: DIJKSTRA_TIMEOUT_EN.
module dijkstra_ctrl #(
  parameter int MAX_NODES = 8,
  parameter int SETTLE    = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] start_id,
  input  logic [15:0] goal_id,
  output logic        mem_find,
  output logic [15:0] mem_node_id,
  input  logic        mem_found,
  input  logic [95:0] mem_child_id,
  input  logic [95:0] mem_child_dist,
  output logic        busy,
  output logic        done,
  output logic        no_path,
  output logic [15:0] path_cost,
  input  logic [15:0] par_addr,
  output logic [15:0] par_data
`ifdef DIJKSTRA_TIMEOUT_EN
  ,
  output logic        timeout_err
`endif
);

  localparam int IW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [15:0] NODES = 16'(MAX_NODES);
  localparam logic [15:0] INF   = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SELECT, S_ISSUE, S_WAIT, S_SETTLE, S_RELAX, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [15:0]          start_q, goal_q;
  logic [15:0]          cost   [MAX_NODES];
  logic [15:0]          parent [MAX_NODES];
  logic [MAX_NODES-1:0] visited;
  logic [SW-1:0]        settle_cnt;
  logic [2:0]           slot;

`ifdef DIJKSTRA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          wait_expired;
  assign wait_expired = (wait_cnt == TW'(TIMEOUT - 1));
`endif

  logic ids_valid;
  assign ids_valid = (start_q < NODES) && (goal_q < NODES);

  // Minimum-cost unvisited node; strict '<' keeps the lowest index on ties.
  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic [15:0]   sel_cost;
  logic          sel_is_goal;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_cost  = INF;
    for (int unsigned i = 0; i < MAX_NODES; i++) begin
      if (!visited[i] && (cost[i] < sel_cost)) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
        sel_cost  = cost[i];
      end
    end
  end

  assign sel_is_goal = sel_found && (16'(sel_idx) == goal_q);

  logic [15:0]   child_id, child_dist, relax_cost;
  logic [IW-1:0] cur_idx, child_idx;
  logic [16:0]   relax_sum;
  logic          relax_upd;

  always_comb begin
    child_id   = mem_child_id[15:0];
    child_dist = mem_child_dist[15:0];
    for (int unsigned k = 0; k < 6; k++) begin
      if (slot == 3'(k)) begin
        child_id   = mem_child_id[16*k +: 16];
        child_dist = mem_child_dist[16*k +: 16];
      end
    end
  end

  assign cur_idx    = mem_node_id[IW-1:0];
  assign child_idx  = child_id[IW-1:0];
  assign relax_sum  = {1'b0, cost[cur_idx]} + {1'b0, child_dist};
  assign relax_cost = relax_sum[16] ? INF : relax_sum[15:0];
  assign relax_upd  = (state == S_RELAX) && (child_id < NODES) && (child_dist != '0) &&
                      !visited[child_idx] && (relax_cost < cost[child_idx]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_INIT;
      S_INIT:   state_nx = ids_valid ? S_SELECT : S_DONE;
      S_SELECT: state_nx = (!sel_found || sel_is_goal) ? S_DONE : S_ISSUE;
      S_ISSUE:  state_nx = S_WAIT;
      S_WAIT: begin
        if (mem_found) state_nx = (SETTLE == 0) ? S_RELAX : S_SETTLE;
`ifdef DIJKSTRA_TIMEOUT_EN
        else if (wait_expired) state_nx = S_DONE;
`endif
      end
      S_SETTLE: if (settle_cnt == SW'(SETTLE - 1)) state_nx = S_RELAX;
      S_RELAX:  if (slot == 3'd5) state_nx = S_SELECT;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign mem_find = (state == S_ISSUE);
  assign done     = (state == S_DONE);
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign par_data = (par_addr < NODES) ? parent[par_addr[IW-1:0]] : INF;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q     <= '0;
      goal_q      <= '0;
      mem_node_id <= '0;
      path_cost   <= '0;
      no_path     <= 1'b0;
      settle_cnt  <= '0;
      slot        <= '0;
      visited     <= '0;
      for (int unsigned i = 0; i < MAX_NODES; i++) begin
        cost[i]   <= INF;
        parent[i] <= INF;
      end
`ifdef DIJKSTRA_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            start_q   <= start_id;
            goal_q    <= goal_id;
            no_path   <= 1'b0;
            path_cost <= '0;
`ifdef DIJKSTRA_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
          end
        end
        S_INIT: begin
          visited <= '0;
          for (int unsigned i = 0; i < MAX_NODES; i++) begin
            cost[i]   <= INF;
            parent[i] <= INF;
          end
          // Later NBA overrides the blanket fill for the source node.
          if (start_q < NODES) cost[start_q[IW-1:0]] <= '0;
          if (!ids_valid) begin
            no_path   <= 1'b1;
            path_cost <= INF;
          end
        end
        S_SELECT: begin
          if (!sel_found) begin
            no_path   <= 1'b1;
            path_cost <= INF;
          end else if (sel_is_goal) begin
            no_path   <= 1'b0;
            path_cost <= sel_cost;
          end else begin
            visited[sel_idx] <= 1'b1;
            mem_node_id      <= 16'(sel_idx);
          end
        end
        S_ISSUE: begin
`ifdef DIJKSTRA_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          settle_cnt <= '0;
          slot       <= '0;
`ifdef DIJKSTRA_TIMEOUT_EN
          wait_cnt <= wait_cnt + 1'b1;
          if (!mem_found && wait_expired) begin
            no_path     <= 1'b1;
            path_cost   <= INF;
            timeout_err <= 1'b1;
          end
`endif
        end
        S_SETTLE: settle_cnt <= settle_cnt + 1'b1;
        S_RELAX: begin
          slot <= slot + 3'd1;
          if (relax_upd) begin
            cost[child_idx]   <= relax_cost;
            parent[child_idx] <= mem_node_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
